instr_fetch_spi: RTL and testbench
==================================

INSTR_FETCH_SPI -- requirements
Module: instr_fetch_spi

Interface
REQ-001: BASE_ADDR, 24'h000000, byte offset in SPI flash where program word 0 is stored.
REQ-002: clk  input  1  system clock; all logic on rising edge.
REQ-003: reset  input  1  synchronous, active-high reset.
REQ-004: fetch_req_i  input  1  request to fetch the word at fetch_addr_i.
REQ-005: fetch_addr_i  input  15  word address of the requested instruction (CPU program counter).
REQ-006: instruction_o  output  16  last fetched instruction word.
REQ-007: instruction_valid_o  output  1  one-cycle pulse: instruction_o holds the word for the accepted request.
REQ-008: busy_o  output  1  high from the cycle after acceptance until the valid pulse, inclusive of neither.
REQ-009: spi_cs_n_o  output  1  flash chip select, active-low.
REQ-010: spi_sck_o  output  1  SPI clock, mode 0, frequency clk/2.
REQ-011: spi_mosi_o  output  1  serial command/address to flash, MSB first.
REQ-012: spi_miso_i  input  1  serial data from flash, MSB first.

Function
REQ-013: A request shall be accepted in any cycle with fetch_req_i=1 and busy_o=0 and instruction_valid_o=0; fetch_addr_i shall be captured only then. Requests while busy are ignored.
REQ-014: The block shall hold a one-entry tag (last fetched address plus a tag-valid bit) and track whether the flash is mid-stream (CS low, next sequential word pending).
REQ-015: States: IDLE, CS_GAP, CMD, ADDR, DATA, DONE.
REQ-016: Hit (tag valid, address equals tag): IDLE->DONE; instruction_valid_o high in the cycle after acceptance (T+1); no SPI activity.
REQ-017: Sequential (stream open, address equals tag+1, tag not 0x7FFF): IDLE->DATA; 16 data bits clocked with CS held low; valid at T+33.
REQ-018: Cold miss (CS high): IDLE->CMD; CS_n falls at T+1; 8 cmd bits 0x03, 24 address bits, 16 data bits; valid at T+97.
REQ-019: Random miss with stream open: IDLE->CS_GAP; CS_n high during T+1..T+2, then as REQ-018 from T+3; valid at T+99.
REQ-020: Flash byte address = BASE_ADDR + {fetch_addr, 1'b0}, modulo 2^24.
REQ-021: Each SPI bit shall occupy 2 clk cycles: SCK low with MOSI driven, then SCK high; MISO sampled on the clk edge that returns SCK low.
REQ-022: The first data byte received is instruction[15:8], the second is instruction[7:0].
REQ-023: spi_mosi_o shall be 0 during DATA and whenever CS_n is high; spi_sck_o shall be 0 whenever CS_n is high and in IDLE/DONE.
REQ-024: After the DATA phase, CS_n shall remain low (stream open); the stream closes only through CS_GAP or reset.
REQ-025: Address 0x7FFF followed by 0x0000 shall be treated as a random miss (REQ-019), not sequential.
REQ-026: On a miss completion, the tag is updated to the fetched address and tag-valid set; instruction_o updates in the valid cycle and holds until the next valid pulse.
REQ-027: DONE lasts exactly one cycle (the valid cycle), then IDLE; earliest next acceptance is the cycle after valid.

Reset
REQ-028: During reset and in the cycle after: state IDLE, spi_cs_n_o=1, spi_sck_o=0, spi_mosi_o=0, busy_o=0, instruction_valid_o=0, instruction_o=16'h0000, tag-valid=0, stream closed.
REQ-029: Reset asserted mid-transaction shall abort it immediately with outputs as REQ-028; no valid pulse for the aborted request.

Verification
REQ-030: After reset, request addr 0x0000, flash model word 0x1234 at byte 0 -> MOSI shows 0x03,0x000000; valid at T+97; instruction_o=0x1234.
REQ-031: Then request 0x0001 (flash 0xABCD) -> no new command, CS stays low, valid at T+33, instruction_o=0xABCD.
REQ-032: Then request 0x0001 again -> valid at T+1, instruction_o=0xABCD, SCK idle.
REQ-033: Then request 0x0100, BASE_ADDR=24'h100000 -> CS_n high 2 cycles, address bits 0x100200, valid at T+99.
REQ-034: Fetch 0x7FFF then 0x0000 -> second fetch uses CS_GAP and full command with address BASE_ADDR+0.
REQ-035: Assert reset at cycle 40 of a cold miss -> CS_n=1 next cycle, no valid pulse; re-request same address -> full miss (T+97), not a hit.

Source files
------------

// File: rtl/instr_fetch_spi.sv
// Instruction fetch unit backed by a SPI NOR flash (READ 0x03, mode 0, SCK = clk/2).
// A one-entry tag gives single-cycle hits; an open read stream gives cheap sequential fetches.
module instr_fetch_spi #(
    parameter logic [23:0] BASE_ADDR = 24'h000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req_i,
    input  logic [14:0] fetch_addr_i,
    output logic [15:0] instruction_o,
    output logic        instruction_valid_o,
    output logic        busy_o,
    output logic        spi_cs_n_o,
    output logic        spi_sck_o,
    output logic        spi_mosi_o,
    input  logic        spi_miso_i,
    output logic [2:0]  dbg_state_o
);

    // Handshake: a request is taken when fetch_req_i=1 in a cycle where busy_o=0 and
    // instruction_valid_o=0; the result is a single-cycle instruction_valid_o pulse.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CS_GAP = 3'd1,
        CMD    = 3'd2,
        ADDR   = 3'd3,
        DATA   = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic        phase_q;
    logic [4:0]  bit_cnt_q;
    logic [31:0] shift_out_q;
    logic [15:0] shift_in_q;
    logic [15:0] instr_q;
    logic [14:0] req_addr_q;
    logic [14:0] tag_q;
    logic        tag_valid_q;
    logic        stream_q;

    logic        accept;
    logic        hit;
    logic        seq;
    logic        shifting;
    logic        bit_last;
    logic [23:0] flash_addr;

    assign accept     = (state_q == IDLE) && fetch_req_i;
    assign hit        = tag_valid_q && (fetch_addr_i == tag_q);
    assign seq        = stream_q && tag_valid_q && (tag_q != 15'h7FFF)
                        && (fetch_addr_i == (tag_q + 15'd1));
    assign flash_addr = BASE_ADDR + {8'h00, fetch_addr_i, 1'b0};
    assign shifting   = (state_q == CMD) || (state_q == ADDR) || (state_q == DATA);

    always_comb begin
        bit_last = 1'b0;
        case (state_q)
            CMD:     bit_last = (bit_cnt_q == 5'd7);
            ADDR:    bit_last = (bit_cnt_q == 5'd23);
            DATA:    bit_last = (bit_cnt_q == 5'd15);
            default: bit_last = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (hit)           state_d = DONE;
                    else if (seq)      state_d = DATA;
                    else if (stream_q) state_d = CS_GAP;
                    else               state_d = CMD;
                end
            end
            CS_GAP:  if (phase_q) state_d = CMD;
            CMD:     if (phase_q && bit_last) state_d = ADDR;
            ADDR:    if (phase_q && bit_last) state_d = DATA;
            DATA:    if (phase_q && bit_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            phase_q     <= 1'b0;
            bit_cnt_q   <= 5'd0;
            shift_out_q <= 32'h0;
            shift_in_q  <= 16'h0;
            instr_q     <= 16'h0;
            req_addr_q  <= 15'h0;
            tag_q       <= 15'h0;
            tag_valid_q <= 1'b0;
            stream_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            // The gap reuses the bit phase so it lasts exactly two cycles.
            phase_q <= (shifting || state_q == CS_GAP) ? ~phase_q : 1'b0;

            if (state_d != state_q)
                bit_cnt_q <= 5'd0;
            else if (shifting && phase_q)
                bit_cnt_q <= bit_cnt_q + 5'd1;

            if (accept) begin
                req_addr_q  <= fetch_addr_i;
                shift_out_q <= {8'h03, flash_addr};
            end else if ((state_q == CMD || state_q == ADDR) && phase_q) begin
                shift_out_q <= {shift_out_q[30:0], 1'b0};
            end

            // MISO is sampled on the edge that drops SCK.
            if (state_q == DATA && phase_q) begin
                shift_in_q <= {shift_in_q[14:0], spi_miso_i};
                if (bit_last) begin
                    instr_q     <= {shift_in_q[14:0], spi_miso_i};
                    tag_q       <= req_addr_q;
                    tag_valid_q <= 1'b1;
                    stream_q    <= 1'b1;
                end
            end

            if (state_q == IDLE && state_d == CS_GAP)
                stream_q <= 1'b0;
        end
    end

    // Outputs are forced to their idle values while reset is held.
    assign spi_cs_n_o          = reset | ~(shifting || (stream_q && (state_q == IDLE || state_q == DONE)));
    assign spi_sck_o           = ~reset & shifting & phase_q;
    assign spi_mosi_o          = ~reset & (state_q == CMD || state_q == ADDR) & shift_out_q[31];
    assign busy_o              = ~reset & (shifting || state_q == CS_GAP);
    assign instruction_valid_o = ~reset & (state_q == DONE);
    assign instruction_o       = reset ? 16'h0000 : instr_q;
    assign dbg_state_o         = state_q;

endmodule

// File: tb/tb_instr_fetch_spi.sv
// Bench for instr_fetch_spi: behavioural SPI flash plus a fetch-level reference model
// (hit / sequential / gap / cold latencies and SPI traffic) driven by directed and random fetches.
module tb_instr_fetch_spi;

    localparam logic [23:0] BASE = 24'h100000;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req_i;
    logic [14:0] fetch_addr_i;
    logic [15:0] instruction_o;
    logic        instruction_valid_o;
    logic        busy_o;
    logic        spi_cs_n_o;
    logic        spi_sck_o;
    logic        spi_mosi_o;
    logic        spi_miso_i;
    logic [2:0]  dbg_state_o;

    instr_fetch_spi #(.BASE_ADDR(BASE)) dut (
        .clk                 (clk),
        .reset               (reset),
        .fetch_req_i         (fetch_req_i),
        .fetch_addr_i        (fetch_addr_i),
        .instruction_o       (instruction_o),
        .instruction_valid_o (instruction_valid_o),
        .busy_o              (busy_o),
        .spi_cs_n_o          (spi_cs_n_o),
        .spi_sck_o           (spi_sck_o),
        .spi_mosi_o          (spi_mosi_o),
        .spi_miso_i          (spi_miso_i),
        .dbg_state_o         (dbg_state_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- flash model ----------------
    logic [7:0]  fmem [logic [23:0]];
    logic [31:0] cmd_q [$];
    int          f_cnt = 0;
    logic [31:0] f_sh = 32'h0;
    logic        f_prev = 1'b0;

    function automatic logic [7:0] fbyte(input logic [23:0] a);
        logic [7:0] h;
        if (fmem.exists(a)) return fmem[a];
        h = a[7:0] ^ {a[14:8], a[15]} ^ a[23:16] ^ 8'h5A;
        return h;
    endfunction

    always @(negedge clk) begin
        logic [23:0] ba;
        logic [7:0]  bv;
        int          k;
        if (spi_cs_n_o) begin
            f_cnt      = 0;
            spi_miso_i = 1'b0;
        end else if (spi_sck_o && !f_prev) begin
            if (f_cnt < 32) f_sh = {f_sh[30:0], spi_mosi_o};
            f_cnt = f_cnt + 1;
            if (f_cnt == 32) cmd_q.push_back(f_sh);
        end else if (!spi_sck_o && f_prev && f_cnt >= 32) begin
            // READ streams bytes from the command address onwards, MSB first.
            k          = f_cnt - 32;
            ba         = f_sh[23:0] + 24'(k / 8);
            bv         = fbyte(ba);
            spi_miso_i = bv[7 - (k % 8)];
        end
        f_prev = spi_sck_o;
    end

    // ---------------- reference model state ----------------
    logic [14:0] m_tag    = 15'h0;
    logic        m_tag_v  = 1'b0;
    logic        m_stream = 1'b0;
    logic [15:0] m_instr  = 16'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag, input logic [15:0] exp_instr);
        check({tag, "_cs_n"},  32'(spi_cs_n_o), 32'd1);
        check({tag, "_sck"},   32'(spi_sck_o), 32'd0);
        check({tag, "_mosi"},  32'(spi_mosi_o), 32'd0);
        check({tag, "_busy"},  32'(busy_o), 32'd0);
        check({tag, "_valid"}, 32'(instruction_valid_o), 32'd0);
        check({tag, "_instr"}, 32'(instruction_o), 32'(exp_instr));
    endtask

    task automatic do_fetch(input logic [14:0] a);
        int lat, cmds, gap, sckn, n, busy_c, csh_c, sck_c, viol_c;
        bit got;
        logic [23:0] fa;
        logic [31:0] c;
        fa = BASE + {8'h00, a, 1'b0};
        if (m_tag_v && a == m_tag) begin
            lat = 1;  cmds = 0; gap = 0; sckn = 0;
        end else if (m_stream && m_tag != 15'h7FFF && a == m_tag + 15'd1) begin
            lat = 33; cmds = 0; gap = 0; sckn = 16;
        end else if (m_stream) begin
            lat = 99; cmds = 1; gap = 2; sckn = 48;
        end else begin
            lat = 97; cmds = 1; gap = 0; sckn = 48;
        end
        if (lat != 1) begin
            m_tag = a; m_tag_v = 1'b1; m_stream = 1'b1;
            m_instr = {fbyte(fa), fbyte(fa + 24'd1)};
        end

        @(posedge clk); #1;
        fetch_req_i  = 1'b1;
        fetch_addr_i = a;
        @(posedge clk); #1;
        fetch_req_i  = 1'b0;
        fetch_addr_i = 15'($urandom_range(0, 32767));
        got = 0; busy_c = 0; csh_c = 0; sck_c = 0; viol_c = 0;
        for (n = 1; n <= 110; n++) begin
            busy_c += int'(busy_o);
            csh_c  += int'(spi_cs_n_o);
            sck_c  += int'(spi_sck_o);
            if (spi_cs_n_o && (spi_sck_o || spi_mosi_o)) viol_c++;
            if (instruction_valid_o) begin
                got = 1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!got) n = 999;
        check($sformatf("latency_%h", a), 32'(n), 32'(lat));
        check($sformatf("instr_%h", a), 32'(instruction_o), 32'(m_instr));
        check($sformatf("busy_cycles_%h", a), 32'(busy_c), 32'(lat - 1));
        check($sformatf("cs_high_cycles_%h", a), 32'(csh_c), 32'(gap));
        check($sformatf("sck_bits_%h", a), 32'(sck_c), 32'(sckn));
        check($sformatf("idle_line_viol_%h", a), 32'(viol_c), 32'd0);
        check($sformatf("cmd_count_%h", a), 32'(cmd_q.size()), 32'(cmds));
        while (cmd_q.size() > 0) begin
            c = cmd_q.pop_front();
            check($sformatf("cmd_addr_%h", a), c, {8'h03, fa});
        end
    endtask

    initial begin
        int vcnt;
        logic [14:0] last, a;
        reset        = 1'b1;
        fetch_req_i  = 1'b0;
        fetch_addr_i = 15'h0;
        fmem[BASE + 24'h000000] = 8'h12;
        fmem[BASE + 24'h000001] = 8'h34;
        fmem[BASE + 24'h000002] = 8'hAB;
        fmem[BASE + 24'h000003] = 8'hCD;
        fmem[BASE + 24'h000200] = 8'h5E;
        fmem[BASE + 24'h000201] = 8'h71;

        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("during_reset", 16'h0000);
        @(posedge clk); #1;
        reset = 1'b0;
        check_idle_outputs("after_reset", 16'h0000);

        // Directed: cold, sequential, hit, random miss, wrap-around.
        do_fetch(15'h0000);
        do_fetch(15'h0001);
        do_fetch(15'h0001);
        check("hit_no_sck", 32'(spi_sck_o), 32'd0);
        do_fetch(15'h0100);
        do_fetch(15'h7FFF);
        do_fetch(15'h0000);
        do_fetch(15'h0001);

        // Reset mid cold-miss.
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_tag_v = 1'b0; m_stream = 1'b0; m_instr = 16'h0;
        check_idle_outputs("clean_reset", 16'h0000);
        @(posedge clk); #1;
        fetch_req_i  = 1'b1;
        fetch_addr_i = 15'h0040;
        @(posedge clk); #1;
        fetch_req_i  = 1'b0;
        repeat (39) @(posedge clk);
        #1;
        check("mid_abort_cs_low", 32'(spi_cs_n_o), 32'd0);
        reset = 1'b1;
        #1;
        check_idle_outputs("abort_in_reset", 16'h0000);
        @(posedge clk); #1;
        reset = 1'b0;
        check_idle_outputs("abort_after", 16'h0000);
        vcnt = 0;
        repeat (110) begin
            vcnt += int'(instruction_valid_o);
            @(posedge clk); #1;
        end
        check("abort_no_valid", 32'(vcnt), 32'd0);
        check("abort_no_cmd", 32'(cmd_q.size()), 32'd0);
        do_fetch(15'h0040);

        // Random mix of hits, sequential, random and wrap addresses.
        last = 15'h0040;
        repeat (24) begin
            case ($urandom_range(0, 4))
                0:       a = last;
                1:       a = last + 15'd1;
                2:       a = 15'($urandom_range(0, 32767));
                3:       a = 15'h7FFF;
                default: a = 15'h0000;
            endcase
            do_fetch(a);
            last = a;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
